// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding and the
//               clock-per-bit / half-bit divisor helpers used by uart_rx and
//               uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM state type; explicit 3-bit encoding kept stable so that
  // legacy tools and waveform viewers decode it the same way everywhere.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Number of system clocks per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Clocks from a start-bit edge to the centre of the start bit.
  function automatic int unsigned half_bit(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer for an asynchronous input.
//               Both stages reset to 1 (idle level of a UART line).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;

  // Two back-to-back flops; the first may go metastable, the second is used.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b1;
      q      <= 1'b1;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8 data bits LSB first, 1 stop bit. Samples
//               each bit at its centre, holds the last byte until read and
//               flags framing errors and overruns.
//               Optional macro UART_RX_PARITY_EN adds one even-parity bit
//               after bit 7 (8E1); a parity mismatch is reported exactly like
//               a bad stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // CLKS_PER_BIT must be at least 2 so that HALF is non-zero.
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF         = half_bit(CLK_FREQ, BAUD);
  localparam int          CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  uart_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_sync_prev;
  logic             w_sync;
  logic             w_fall;
  logic             w_half_done;
  logic             w_bit_done;
  logic             w_stop_ok;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (w_sync)
  );

  assign w_fall      = r_sync_prev & ~w_sync;
  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_bit_done  = (r_cnt == BIT_LAST);
  assign busy        = (r_state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic r_par_ok;
  assign w_stop_ok = w_sync & r_par_ok;
`else
  assign w_stop_ok = w_sync;
`endif

  // Previous synchronized level for start-edge detection; a line held low
  // after a framing error never produces a new falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync_prev <= 1'b1;
    end else begin
      r_sync_prev <= w_sync;
    end
  end

  // Receive FSM, bit timing, shift register and the output/status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_ok  <= 1'b1;
`endif
    end else begin
      frame_err <= 1'b0;
      // A read clears valid; a byte accepted in the same cycle overrides it.
      if (rd_en) begin
        valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= 3'd0;
          if (w_fall) begin
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_half_done) begin
            r_cnt   <= '0;
            // Line back high at the start-bit centre is a glitch.
            r_state <= w_sync ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_shift   <= {w_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_done) begin
            r_cnt    <= '0;
            // Even parity: data bits plus parity bit hold an even count of ones.
            r_par_ok <= ~(^{r_shift, w_sync});
            r_state  <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (w_stop_ok) begin
              data_out <= r_shift;
              valid    <= 1'b1;
              if (valid && !rd_en) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Serial frames are generated
//               here; a frame-level model tracks the expected byte, valid,
//               overrun and event counts and is compared after every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 62_500;
  localparam int CPB  = CLK_FREQ / BAUD;   // 16
  localparam int HALF = CPB / 2;           // 8
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Stop-bit centre measured from the start edge.
  localparam int STOP_CENTRE = (FRAME_BITS - 1) * CPB + HALF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model state
  logic [7:0] exp_data  = 8'h00;
  bit         exp_valid = 1'b0;
  bit         exp_ov    = 1'b0;
  int         exp_ferr  = 0;
  int         exp_vrise = 0;

  // Observed events
  int ferr_cnt  = 0;
  int vrise_cnt = 0;
  int vrise_cyc = 0;

  bit auto_read    = 1'b0;
  int rd_pulse_cyc = -1;
  int start_cyc    = 0;
  int lat          = STOP_CENTRE + 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: event counting and cycle-level rules.
  initial begin : monitor
    logic       pv, pfe, pov;
    logic [7:0] pdata;
    pv = 0; pfe = 0; pov = 0; pdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (valid && !pv) begin
          vrise_cnt++;
          vrise_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (pfe) chk("frame_err_one_cycle", frame_err, 0);
        if (pov) chk("overrun_sticky", overrun, 1);
        if (data_out !== pdata) chk("data_change_sets_valid", valid, 1);
      end
      pv = valid; pfe = frame_err; pov = overrun; pdata = data_out;
    end
  end

  // Consumer: either reads each byte as it appears or pulses rd_en at one
  // chosen cycle.
  initial begin : reader
    forever begin
      @(negedge clk);
      if (auto_read) rd_en = valid && !rd_en;
      else           rd_en = (cyc == rd_pulse_cyc);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic drive_bit(input logic v);
    din = v;
    repeat (CPB) @(negedge clk);
  endtask

  // mode: 0 = no read, 1 = consumer reads each byte, 2 = rd_en on accept cycle
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int mode);
    start_cyc    = cyc;
    auto_read    = (mode == 1);
    rd_pulse_cyc = (mode == 2) ? start_cyc + lat - 1 : -1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ ~par_ok);
`endif
    drive_bit(stop_ok);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good, input int mode);
    if (good) begin
      exp_data = b;
      if (mode == 1) begin
        exp_vrise++;
        exp_valid = 0;
      end else begin
        if (!exp_valid) exp_vrise++;
        else if (mode == 0) exp_ov = 1;
        exp_valid = 1;
      end
    end else begin
      exp_ferr++;
      if (mode != 0) exp_valid = 0;
    end
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, ".data_out"}, data_out, exp_data);
    chk({tag, ".valid"}, valid, exp_valid);
    chk({tag, ".overrun"}, overrun, exp_ov);
    chk({tag, ".frame_err_count"}, ferr_cnt, exp_ferr);
    chk({tag, ".valid_rise_count"}, vrise_cnt, exp_vrise);
    chk({tag, ".busy"}, busy, 0);
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                       input int mode, input string tag);
    send_frame(b, stop_ok, par_ok, mode);
    model_frame(b, stop_ok && par_ok, mode);
    checkpoint(tag);
  endtask

  initial begin : stim
    bit prev_bad;
    bit busy_seen;
    int n;
    int vr0, fe0;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset.data_out", data_out, 8'h00);
    chk("reset.valid", valid, 0);
    chk("reset.frame_err", frame_err, 0);
    chk("reset.overrun", overrun, 0);
    chk("reset.busy", busy, 0);
    repeat (4) @(negedge clk);

    // Single clean byte; also measures the acceptance latency
    frame(8'h41, 1, 1, 0, "byte41");
    lat = vrise_cyc - start_cyc;
    chk("accept_latency_in_window", (lat >= STOP_CENTRE && lat <= STOP_CENTRE + 4), 1);
    chk("byte41.literal_data", data_out, 8'h41);
    chk("byte41.literal_ferr", ferr_cnt, 0);

    // Short glitch on the line: rejected, busy drops back
    vr0 = vrise_cnt; fe0 = ferr_cnt;
    din = 1'b0;
    busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    din = 1'b1;
    n = 0;
    while (busy && n < HALF + 3) begin
      @(negedge clk);
      n++;
    end
    chk("glitch.busy_seen", busy_seen, 1);
    chk("glitch.busy_returns", busy, 0);
    repeat (CPB) @(negedge clk);
    chk("glitch.no_valid", vrise_cnt, vr0);
    chk("glitch.no_ferr", ferr_cnt, fe0);
    checkpoint("glitch");

    // Bad stop bit followed by a held break
    send_frame(8'hA5, 0, 1, 0);
    repeat (3 * CPB) @(negedge clk);
    din = 1'b1;
    repeat (CPB) @(negedge clk);
    model_frame(8'hA5, 0, 0);
    checkpoint("bad_stop");
    chk("bad_stop.literal_data_kept", data_out, 8'h41);

    // 16 back-to-back frames with the consumer reading each one
    vr0 = vrise_cnt;
    for (int i = 0; i < 16; i++) frame(8'h41, 1, 1, 1, "burst16");
    chk("burst16.valid_events", vrise_cnt - vr0, 16);
    chk("burst16.literal_overrun", overrun, 0);
    auto_read = 0;
    repeat (4) @(negedge clk);

    // Read and acceptance in the same cycle: new byte wins, no overrun
    frame(8'h41, 1, 1, 0, "pre_same_cycle");
    frame(8'h42, 1, 1, 2, "same_cycle");
    chk("same_cycle.literal_valid", valid, 1);
    chk("same_cycle.literal_overrun", overrun, 0);
    repeat (3) @(negedge clk);

    // Two frames back-to-back without reading: overrun
    frame(8'h41, 1, 1, 0, "ovr_a");
    frame(8'h42, 1, 1, 0, "ovr_b");
    chk("overrun.literal_data", data_out, 8'h42);
    chk("overrun.literal_valid", valid, 1);
    chk("overrun.literal_overrun", overrun, 1);

    // Reset in the middle of bit 4 abandons the frame
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    din = 1'b0;
    repeat (HALF) @(negedge clk);
    rst = 1'b0;
    din = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset.data_out", data_out, 8'h00);
    chk("midreset.valid", valid, 0);
    chk("midreset.overrun", overrun, 0);
    chk("midreset.busy", busy, 0);
    exp_data = 8'h00; exp_valid = 0; exp_ov = 0;
    repeat (2 * CPB) @(negedge clk);
    checkpoint("midreset_quiet");
    frame(8'h55, 1, 1, 0, "after_reset");
    chk("after_reset.literal_data", data_out, 8'h55);

`ifdef UART_RX_PARITY_EN
    vr0 = vrise_cnt; fe0 = ferr_cnt;
    frame(8'h41, 1, 0, 1, "bad_parity");
    chk("bad_parity.ferr_pulse", ferr_cnt - fe0, 1);
    chk("bad_parity.no_valid", vrise_cnt - vr0, 0);
    repeat (4) @(negedge clk);
`endif

    // Randomized frames, gaps and consumer behaviour
    prev_bad = 0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      bit so, po;
      int mode, gap;
      b    = 8'($urandom);
      so   = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      po   = ($urandom_range(0, 7) != 0);
`else
      po   = 1;
`endif
      mode = $urandom_range(0, 2);
      gap  = $urandom_range(0, 12);
      if (prev_bad && gap < 4) gap = 4;
      din = 1'b1;
      repeat (gap) @(negedge clk);
      frame(b, so, po, mode, "random");
      prev_bad = !so;
    end
    auto_read = 0;
    rd_pulse_cyc = -1;
    din = 1'b1;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din  input  1  asynchronous serial line, idle high, 8N1 (8E1 with parity).
REQ-006 SHALL have port data_out  output  8  last received byte, LSB received first.
REQ-007 SHALL have port valid  output  1  high while data_out holds an unread byte.
REQ-008 SHALL have port rd_en  input  1  consumer acknowledge; clears valid.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky; byte completed while valid was high.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 SHALL pass din through a 2-flop synchronizer before any use; 2-cycle input latency.
REQ-013 SHALL define CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 868 at defaults) and HALF = CLKS_PER_BIT/2.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on synchronized falling edge (previous 1, current 0); bit counter cleared.
REQ-016 START: after HALF cycles sample line; low -> DATA, high -> IDLE (glitch reject, no outputs change).
REQ-017 DATA: sample every CLKS_PER_BIT cycles from start-bit centre; shift 8 bits LSB first; after bit 7 -> PARITY if enabled, else STOP.
REQ-018 STOP: sample at bit centre; high -> byte accepted; low -> frame_err pulses 1 cycle, byte discarded, valid/data_out unchanged; both -> IDLE same cycle.
REQ-019 Accepted byte SHALL load data_out and set valid on the cycle after the stop-bit centre sample.
REQ-020 valid SHALL stay high until sampled rd_en=1; rd_en with valid=0 SHALL be ignored.
REQ-021 Byte accepted while valid=1 and rd_en=0: data_out overwritten, valid stays 1, overrun set.
REQ-022 Byte acceptance and rd_en in the same cycle: new byte wins, valid stays 1, no overrun.
REQ-023 overrun SHALL clear only on reset.
REQ-024 After frame error, IDLE SHALL require line high before detecting a new start (break held low does not retrigger).
REQ-025 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-026 rst=0 at a rising edge SHALL force state IDLE, counters 0, data_out=8'h00, valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; no valid or frame_err generated for it.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state present, one even-parity bit after bit 7; mismatch treated like a frame error (frame_err pulse, byte discarded).
REQ-029 Macro UART_RX_PARITY_EN undefined: PARITY state and logic absent; DATA goes directly to STOP; 8N1 framing.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state typedef and the CLKS_PER_BIT/HALF computation function, shared with uart_tx.
REQ-031 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value 1).

Verification
REQ-032 uart_tx (same CLK_FREQ/BAUD) sends 8'h41 -> valid rises once, data_out=8'h41, frame_err=0.
REQ-033 din low for 3 cycles then high -> no valid, no frame_err, busy returns 0 within HALF+3 cycles.
REQ-034 Frame 8'hA5 with stop bit forced low -> frame_err 1-cycle pulse, valid stays 0, data_out unchanged.
REQ-035 Two frames 8'h41, 8'h42 back-to-back, rd_en held 0 -> data_out=8'h42, valid=1, overrun=1.
REQ-036 16 frames 8'h41 back-to-back, rd_en pulsed after each valid -> 16 valid events, overrun=0.
REQ-037 rst=0 during bit 4 of a frame, then release -> all outputs at reset values, next clean 8'h55 received correctly; with UART_RX_PARITY_EN, wrong parity on 8'h41 -> frame_err pulse, no valid.
